rca_seq_ctrl: RTL and testbench

- Nibble-serial adder controller. One RCA_4bit slice is shared across WIDTH/4 clock cycles to add WIDTH-bit operands, least-significant nibble first.
- Sits between a valid/ready operand source and a valid/ready result sink. Trades latency for area compared with a full-width ripple chain.
- Sequences slice operands, holds the inter-nibble carry in a register, assembles the sum, and flags carry-out and signed overflow.

---
 rtl/rca_seq_ctrl_if.sv | 32 +++
 rtl/rca_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle for rca_seq_ctrl.
// master: operand source + result sink side. slave: the controller itself.
// Both channels use plain valid/ready. A transfer happens on a rising clock
// edge where valid and ready are both high. A source holds valid and its data
// stable until that edge. Ready may depend combinationally on the state of the
// receiving side.
interface rca_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial adder controller: one 4-bit ripple-carry slice is reused over
// WIDTH/4 cycles, least-significant nibble first, with the inter-nibble carry
// kept in a register.
// Optional feature macro: RCA_SEQ_SUB_EN. When it is defined, op_sub=1 selects
// a - b (b inverted, carry-in forced to 1). When it is undefined, op_sub is
// ignored and the result is a + b + cin.
// dbg_state exposes the FSM state (0=IDLE, 1=RUN, 2=DONE).
module rca_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  rca_seq_ctrl_if.slave     bus,
  output logic [1:0]        dbg_state
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One 4-bit ripple-carry slice: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c);
    logic       c_r;
    logic [3:0] s;
    c_r = c;
    s   = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c_r;
      c_r  = (x[i] & y[i]) | (c_r & (x[i] ^ y[i]));
    end
    return {c_r, s};
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             in_ready_w;
  logic             accept_w;
  logic [WIDTH-1:0] b_eff_w;
  logic             c0_w;
  logic [3:0]       slice_a_w;
  logic [3:0]       slice_b_w;
  logic [4:0]       slice_w;

  // Operand conditioning at accept time: subtract maps to a + ~b + 1.
`ifdef RCA_SEQ_SUB_EN
  assign b_eff_w = bus.op_sub ? ~bus.b : bus.b;
  assign c0_w    = bus.op_sub ? 1'b1 : bus.cin;
`else
  logic unused_op_sub;
  assign unused_op_sub = bus.op_sub;
  assign b_eff_w = bus.b;
  assign c0_w    = bus.cin;
`endif

  // Ready when idle, or when the held result is being taken this same edge.
  assign in_ready_w = ~rst & ((state_q == ST_IDLE) |
                              ((state_q == ST_DONE) & bus.out_ready));
  assign accept_w   = bus.in_valid & in_ready_w;

  // Current nibble fed into the shared slice.
  assign slice_a_w = a_q[{cnt_q, 2'b00} +: 4];
  assign slice_b_w = b_q[{cnt_q, 2'b00} +: 4];
  assign slice_w   = rca4(slice_a_w, slice_b_w, carry_q);

  // Next-state and datapath update for the whole controller.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      ST_RUN: begin
        sum_d[{cnt_q, 2'b00} +: 4] = slice_w[3:0];
        carry_d = slice_w[4];
        if (cnt_q == CNT_LAST) begin
          cout_d      = slice_w[4];
          ovf_d       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                        (slice_w[3] != a_q[WIDTH-1]);
          cnt_d       = '0;
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready && !bus.in_valid) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new operation (from IDLE, or back-to-back out of DONE) restarts the pass.
    if (accept_w) begin
      a_d         = bus.a;
      b_d         = b_eff_w;
      carry_d     = c0_w;
      cnt_d       = '0;
      sum_d       = '0;
      cout_d      = 1'b0;
      ovf_d       = 1'b0;
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
      busy_d      = 1'b1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (WIDTH=16). Expected values are hand-computed.
// The subtract vectors are selected with RCA_SEQ_SUB_EN, matching the DUT build.
module tb_rca_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks;
  int n_pass;

  rca_seq_ctrl_if #(.WIDTH(16)) bus ();

  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and let it be accepted on the next edge.
  task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic sv);
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    bus.op_sub   = sv;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge: measure latency and busy, check result.
  task automatic wait_done(input string tag, input logic [15:0] es, input logic ec,
                           input logic eo);
    int n;
    int bc;
    n  = 0;
    bc = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) bc++;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd4);
    chk({tag, "_busy_cycles"}, bc, 32'd4);
    chk({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, es});
    chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
    chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Take the held result and confirm return to IDLE.
  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_drain_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int saw;
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();

    // Plain add
    start_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done("add1", 16'h5555, 1'b0, 1'b0);
    chk("add1_in_ready_held", {31'd0, bus.in_ready}, 32'd0);
    drain("add1");

    // Unsigned wrap with carry out
    start_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done("wrap", 16'h0000, 1'b1, 1'b0);
    drain("wrap");

    // Signed overflow via carry-in
    start_op("ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    wait_done("ovf", 16'h8000, 1'b0, 1'b1);
    drain("ovf");

    // Negative + negative: both carry and overflow
    start_op("negneg", 16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_done("negneg", 16'h0000, 1'b1, 1'b1);
    drain("negneg");

    // Backpressure then back-to-back accept
    start_op("bp", 16'h1111, 16'h1111, 1'b0, 1'b0);
    wait_done("bp", 16'h2222, 1'b0, 1'b0);
    bus.a        = 16'hAAAA;
    bus.b        = 16'h0000;
    bus.cin      = 1'b0;
    bus.op_sub   = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_sum", {16'd0, bus.sum}, 32'h2222);
      chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("b2b_sum_cleared", {16'd0, bus.sum}, 32'd0);
    wait_done("b2b", 16'hAAAA, 1'b0, 1'b0);
    drain("b2b");

    // Reset mid-RUN (partial sum 0x000E is in flight when rst hits)
    start_op("midrst", 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sum", {16'd0, bus.sum}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid === 1'b1) saw = 1;
    end
    chk("midrst_no_valid", saw, 32'd0);

`ifdef RCA_SEQ_SUB_EN
    // Subtract: 5 - 7 and signed overflow on 0x8000 - 1
    start_op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("sub1", 16'hFFFE, 1'b0, 1'b0);
    drain("sub1");
    start_op("sub2", 16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_done("sub2", 16'h7FFF, 1'b1, 1'b1);
    drain("sub2");
`else
    // op_sub has no effect in the default build
    start_op("nosub", 16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done("nosub", 16'h000C, 1'b0, 1'b0);
    drain("nosub");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
